// File: rtl/bcd_updn_counter.sv
// rtl/bcd_updn_counter.sv - multi-decade loadable BCD up/down counter with modulus, saturate and cascade
module bcd_updn_counter #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  RESET_B,
  input  logic                  LOAD,
  input  logic                  EN,
  input  logic                  CI,
  input  logic                  UP,
  input  logic                  MODE,
  input  logic [4*DIGITS-1:0]   LIMIT,
  input  logic [4*DIGITS-1:0]   IN,
  input  logic                  OVF_CLR,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  RC,
  output logic                  TC,
  output logic                  OVF
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (b) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Load values are sanitised digit by digit so Q never holds an invalid decade.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = (v[4*d +: 4] > 4'd9) ? 4'd9 : v[4*d +: 4];
    end
    return r;
  endfunction

  logic at_top;
  logic at_zero;
  logic at_term;
  logic step;
  logic term;

  assign at_top  = (Q >= LIMIT);
  assign at_zero = (Q == '0);
  assign at_term = UP ? at_top : at_zero;
  assign step    = EN & CI;
  assign term    = step & at_term;
  assign RC      = CI & at_term;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      Q   <= RST_VAL;
      TC  <= 1'b0;
      OVF <= 1'b0;
    end else begin
      TC <= 1'b0;
      if (OVF_CLR) begin
        OVF <= 1'b0;
      end
      if (LOAD) begin
        Q <= bcd_clamp(IN);
      end else if (step) begin
        if (term) begin
          TC  <= 1'b1;
          OVF <= 1'b1;
          if (!MODE) begin
            Q <= UP ? '0 : LIMIT;
          end
        end else begin
          Q <= UP ? bcd_inc(Q) : bcd_dec(Q);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updn_counter.sv
// tb/tb_bcd_updn_counter.sv - directed self-checking bench for bcd_updn_counter
module tb_bcd_updn_counter;

  logic       clk;
  logic       rst_n;
  logic       load, en, ci, up, mode, ovf_clr;
  logic [7:0] limit, din;
  logic [7:0] q;
  logic       rc, tc, ovf;

  logic       c_load, c_en, c_ci;
  logic [7:0] c_in_lo, c_in_hi;
  logic [7:0] q_lo, q_hi;
  logic       rc_lo, rc_hi, tc_lo, tc_hi, ovf_lo, ovf_hi;

  int checks;
  int failures;

  bcd_updn_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_dut (
    .CLK(clk), .RESET_B(rst_n), .LOAD(load), .EN(en), .CI(ci), .UP(up),
    .MODE(mode), .LIMIT(limit), .IN(din), .OVF_CLR(ovf_clr),
    .Q(q), .RC(rc), .TC(tc), .OVF(ovf)
  );

  bcd_updn_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_lo (
    .CLK(clk), .RESET_B(rst_n), .LOAD(c_load), .EN(c_en), .CI(c_ci), .UP(1'b1),
    .MODE(1'b0), .LIMIT(8'h99), .IN(c_in_lo), .OVF_CLR(1'b0),
    .Q(q_lo), .RC(rc_lo), .TC(tc_lo), .OVF(ovf_lo)
  );

  bcd_updn_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_hi (
    .CLK(clk), .RESET_B(rst_n), .LOAD(c_load), .EN(c_en), .CI(rc_lo), .UP(1'b1),
    .MODE(1'b0), .LIMIT(8'h99), .IN(c_in_hi), .OVF_CLR(1'b0),
    .Q(q_hi), .RC(rc_hi), .TC(tc_hi), .OVF(ovf_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    load = 0; en = 0; ci = 1; up = 1; mode = 0; ovf_clr = 0;
    limit = 8'h59; din = 8'h00;
    c_load = 0; c_en = 0; c_ci = 1; c_in_lo = 8'h00; c_in_hi = 8'h00;
    #3;
    check("rst_q", q, 8'h00);
    check("rst_tc", tc, 0);
    check("rst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;

    // up wrap at LIMIT=59
    load = 1; din = 8'h57; tick(); load = 0;
    check("wrap_load", q, 8'h57);
    en = 1; tick();
    check("wrap_q58", q, 8'h58);
    check("wrap_rc58", rc, 0);
    tick();
    check("wrap_q59", q, 8'h59);
    check("wrap_rc59", rc, 1);
    check("wrap_tc59", tc, 0);
    tick();
    check("wrap_q00", q, 8'h00);
    check("wrap_tc00", tc, 1);
    check("wrap_ovf", ovf, 1);
    tick();
    check("wrap_q01", q, 8'h01);
    check("wrap_tc01", tc, 0);
    check("wrap_ovf_sticky", ovf, 1);
    en = 0;

    // async reset mid-count beats a pending load
    load = 1; din = 8'h37; tick(); load = 0;
    check("pre_rst_q", q, 8'h37);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 8'h00);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_tc", tc, 0);
    load = 1; din = 8'h55; tick();
    check("rst_hold_q", q, 8'h00);
    load = 0; rst_n = 1'b1;

    // BCD carry and borrow
    limit = 8'h99; mode = 0;
    load = 1; din = 8'h09; tick(); load = 0;
    up = 1; en = 1; tick(); en = 0;
    check("carry_10", q, 8'h10);
    load = 1; din = 8'h10; tick(); load = 0;
    up = 0; en = 1; tick(); en = 0;
    check("borrow_09", q, 8'h09);
    load = 1; din = 8'h00; tick(); load = 0;
    #1;
    check("rc_down_zero", rc, 1);
    en = 1; tick(); en = 0;
    check("down_wrap_q", q, 8'h99);
    check("down_wrap_tc", tc, 1);
    tick();
    check("down_wrap_tc_end", tc, 0);

    // saturate mode
    mode = 1; limit = 8'h23; up = 1;
    load = 1; din = 8'h23; tick(); load = 0;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_up_q", q, 8'h23);
      check("sat_up_tc", tc, 1);
    end
    en = 0; tick();
    check("sat_tc_end", tc, 0);
    load = 1; din = 8'h00; tick(); load = 0;
    up = 0; en = 1; tick(); en = 0;
    check("sat_dn_q", q, 8'h00);
    check("sat_dn_tc", tc, 1);
    tick();
    check("sat_dn_tc_end", tc, 0);

    // OVF clear, load priority and digit clamp, set-wins-over-clear
    ovf_clr = 1; tick(); ovf_clr = 0;
    check("ovf_clr_alone", ovf, 0);
    load = 1; en = 1; up = 1; din = 8'hA7; tick(); load = 0; en = 0;
    check("clamp_q", q, 8'h97);
    check("load_no_tc", tc, 0);
    en = 1; ovf_clr = 1; tick(); en = 0;
    check("above_limit_hold", q, 8'h97);
    check("set_wins_ovf", ovf, 1);
    check("set_wins_tc", tc, 1);
    tick(); ovf_clr = 0;
    check("ovf_clr_after", ovf, 0);

    // CI=0 blocks steps and RC
    mode = 0; limit = 8'h99;
    load = 1; din = 8'h10; tick(); load = 0;
    ci = 0; en = 1; tick(); en = 0;
    check("ci_block_q", q, 8'h10);
    check("ci_block_rc", rc, 0);
    ci = 1;

    // two-stage cascade
    c_load = 1; c_in_lo = 8'h99; c_in_hi = 8'h99; tick(); c_load = 0;
    check("casc_rc_lo", rc_lo, 1);
    check("casc_rc_hi", rc_hi, 1);
    c_en = 1; tick();
    check("casc_9999_lo", q_lo, 8'h00);
    check("casc_9999_hi", q_hi, 8'h00);
    check("casc_tc_hi", tc_hi, 1);
    tick();
    check("casc_0001_lo", q_lo, 8'h01);
    check("casc_0001_hi", q_hi, 8'h00);
    c_en = 0;
    c_load = 1; c_in_lo = 8'h98; c_in_hi = 8'h05; tick(); c_load = 0;
    c_en = 1; tick();
    check("casc_0599", {q_hi, q_lo}, 16'h0599);
    tick();
    check("casc_0600", {q_hi, q_lo}, 16'h0600);
    c_ci = 0; tick();
    check("casc_ci_block", {q_hi, q_lo}, 16'h0600);
    c_en = 0; c_ci = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
